// File: rtl/hex_entry_controller.sv
// ---------------------------------------------------------------------------
// hex_entry_controller
//
// Front-panel hex entry for the 16-bit CPU board. The operator shifts nibbles
// in from the switches with the digit key, then commits the assembled value
// to a chosen register through a request/acknowledge write port. The clear
// key discards a partial entry.
//
// Ports:
//   clk           system clock, rising edge
//   resetn        asynchronous active-low reset
//   sw[3:0]       nibble shifted in on a digit press
//   reg_sel[3:0]  destination register, captured at commit
//   key_digit_n   raw active-low digit button
//   key_commit_n  raw active-low commit button
//   key_clear_n   raw active-low clear button
//   wr_ack        register file accepted the pending write
//   wr_req        write request, held until wr_ack
//   wr_addr[3:0]  write address, stable while wr_req is high
//   wr_data[15:0] write data, stable while wr_req is high
//   entry_val     value under construction (drives the display)
//   digit_cnt     digits entered so far, 0..4
//   busy          high while a write is outstanding
// ---------------------------------------------------------------------------
module hex_entry_controller #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [3:0]  sw,
    input  logic [3:0]  reg_sel,
    input  logic        key_digit_n,
    input  logic        key_commit_n,
    input  logic        key_clear_n,
    input  logic        wr_ack,
    output logic        wr_req,
    output logic [3:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic [15:0] entry_val,
    output logic [2:0]  digit_cnt,
    output logic        busy
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ENTRY,
        WRITE
    } state_t;

    state_t     state;
    logic [2:0] raw_n;
    logic [2:0] press;
    logic       digit_ev;
    logic       commit_ev;
    logic       clear_ev;

    assign raw_n     = {key_clear_n, key_commit_n, key_digit_n};
    assign digit_ev  = press[0];
    assign commit_ev = press[1];
    assign clear_ev  = press[2];

    // One conditioning chain per key: two-flop synchronizer, then a debouncer
    // that only adopts the new level after it has been seen for
    // DEBOUNCE_CYCLES cycles in a row. The press pulse is registered at the
    // same edge the debounced level falls, so it lasts exactly one cycle.
    for (genvar k = 0; k < 3; k++) begin : g_key
        logic          sync1;
        logic          sync2;
        logic          level;
        logic          pulse;
        logic [CW-1:0] cnt;

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                sync1 <= 1'b1;
                sync2 <= 1'b1;
                level <= 1'b1;
                pulse <= 1'b0;
                cnt   <= '0;
            end else begin
                sync1 <= raw_n[k];
                sync2 <= sync1;
                pulse <= 1'b0;
                if (sync2 == level) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    level <= sync2;
                    cnt   <= '0;
                    pulse <= ~sync2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign press[k] = pulse;
    end

    // Entry state machine. All outputs are registered here; busy and wr_req
    // move together because both mean "state is WRITE". In ENTRY, clear wins
    // over commit, which wins over digit; a fifth digit is simply ignored.
    // In WRITE every key event is dropped until the register file acks.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            wr_req    <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            entry_val <= '0;
            digit_cnt <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (digit_ev) begin
                        entry_val <= {12'h000, sw};
                        digit_cnt <= 3'd1;
                        state     <= ENTRY;
                    end
                end
                ENTRY: begin
                    if (clear_ev) begin
                        entry_val <= '0;
                        digit_cnt <= '0;
                        state     <= IDLE;
                    end else if (commit_ev) begin
                        wr_addr <= reg_sel;
                        wr_data <= entry_val;
                        wr_req  <= 1'b1;
                        busy    <= 1'b1;
                        state   <= WRITE;
                    end else if (digit_ev && (digit_cnt < 3'd4)) begin
                        entry_val <= {entry_val[11:0], sw};
                        digit_cnt <= digit_cnt + 3'd1;
                    end
                end
                WRITE: begin
                    if (wr_ack) begin
                        wr_req    <= 1'b0;
                        busy      <= 1'b0;
                        entry_val <= '0;
                        digit_cnt <= '0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hex_entry_controller.sv
// ---------------------------------------------------------------------------
// tb_hex_entry_controller
//
// Self-checking bench for hex_entry_controller with a short debounce so key
// presses complete in a few cycles. A table of key operations with expected
// entry state drives the main flow; each commit pushes its expected write
// into a queue that is popped when the design raises wr_req. Hand-written
// sequences cover bounce, simultaneous keys, clear during a write and reset
// in the middle of a write.
// ---------------------------------------------------------------------------
module tb_hex_entry_controller;

    localparam int D = 4;

    typedef enum int {OP_DIGIT, OP_COMMIT, OP_CLEAR} op_t;

    typedef struct {
        op_t         op;
        logic [3:0]  sw;
        logic [3:0]  sel;
        int          ack_delay;
        logic [15:0] exp_entry;
        logic [2:0]  exp_cnt;
    } vec_t;

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] data;
    } wr_t;

    logic        clk;
    logic        resetn;
    logic [3:0]  sw;
    logic [3:0]  reg_sel;
    logic        key_digit_n;
    logic        key_commit_n;
    logic        key_clear_n;
    logic        wr_ack;
    logic        wr_req;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [15:0] entry_val;
    logic [2:0]  digit_cnt;
    logic        busy;

    int          checks;
    int          failures;
    logic        saw_req;
    logic [15:0] cur_entry;
    logic [2:0]  cur_cnt;
    vec_t        vecs[$];
    wr_t         exp_q[$];

    hex_entry_controller #(.DEBOUNCE_CYCLES(D)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .sw           (sw),
        .reg_sel      (reg_sel),
        .key_digit_n  (key_digit_n),
        .key_commit_n (key_commit_n),
        .key_clear_n  (key_clear_n),
        .wr_ack       (wr_ack),
        .wr_req       (wr_req),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .entry_val    (entry_val),
        .digit_cnt    (digit_cnt),
        .busy         (busy)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports any miss.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Advance n falling edges, remembering whether wr_req was ever seen high.
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            if (wr_req === 1'b1) saw_req = 1'b1;
        end
    endtask

    // Clean press-and-release of any combination of keys, long enough for
    // both edges to pass the debouncer.
    task automatic pressKeys(input bit d, input bit c, input bit cl);
        key_digit_n  = ~d;
        key_commit_n = ~c;
        key_clear_n  = ~cl;
        tick(D + 6);
        key_digit_n  = 1'b1;
        key_commit_n = 1'b1;
        key_clear_n  = 1'b1;
        tick(D + 6);
    endtask

    // Commit with wr_ack raised so that it is sampled in the ack_delay-th
    // wr_req cycle (0 means wr_ack is already held high beforehand).
    task automatic doCommit(input logic [3:0] sel, input int ack_delay);
        int  cycles;
        int  high;
        bit  stable;
        wr_t expw;
        reg_sel = sel;
        if (ack_delay == 0) wr_ack = 1'b1;
        key_commit_n = 1'b0;
        cycles = 0;
        while (wr_req !== 1'b1 && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        if (wr_req !== 1'b1 || exp_q.size() == 0) begin
            checkOutput("wr_req_timeout", 32'(wr_req), 32'd1);
        end else begin
            expw = exp_q.pop_front();
            checkOutput("wr_addr", 32'(wr_addr), 32'(expw.addr));
            checkOutput("wr_data", 32'(wr_data), 32'(expw.data));
            high   = 0;
            stable = 1'b1;
            while (wr_req === 1'b1 && high < 40) begin
                high++;
                if (wr_addr !== expw.addr || wr_data !== expw.data || busy !== 1'b1)
                    stable = 1'b0;
                if (high == ack_delay) wr_ack = 1'b1;
                @(negedge clk);
            end
            checkOutput("wr_hold_stable", 32'(stable), 32'd1);
            checkOutput("wr_req_cycles", 32'(high), (ack_delay == 0) ? 32'd1 : 32'(ack_delay));
        end
        if (ack_delay != 0) wr_ack = 1'b0;
        key_commit_n = 1'b1;
        saw_req = 1'b0;
        tick(D + 6);
        checkOutput("single_write", 32'(saw_req), 32'd0);
        wr_ack = 1'b0;
        tick(2);
    endtask

    // Apply one table record using the bench's own view of the entry state.
    task automatic applyStimulus(input vec_t v);
        case (v.op)
            OP_DIGIT: begin
                sw = v.sw;
                pressKeys(1'b1, 1'b0, 1'b0);
            end
            OP_CLEAR: begin
                pressKeys(1'b0, 1'b0, 1'b1);
            end
            default: begin
                if (cur_cnt != 3'd0) begin
                    exp_q.push_back('{addr: v.sel, data: cur_entry});
                    doCommit(v.sel, v.ack_delay);
                end else begin
                    reg_sel = v.sel;
                    saw_req = 1'b0;
                    pressKeys(1'b0, 1'b1, 1'b0);
                    checkOutput("idle_commit_ignored", 32'(saw_req), 32'd0);
                end
            end
        endcase
        checkOutput("entry_val", 32'(entry_val), 32'(v.exp_entry));
        checkOutput("digit_cnt", 32'(digit_cnt), 32'(v.exp_cnt));
        checkOutput("busy_idle", 32'(busy), 32'd0);
        cur_entry = v.exp_entry;
        cur_cnt   = v.exp_cnt;
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        saw_req      = 1'b0;
        cur_entry    = '0;
        cur_cnt      = '0;
        resetn       = 1'b0;
        sw           = 4'h0;
        reg_sel      = 4'h0;
        wr_ack       = 1'b0;
        key_digit_n  = 1'b0;
        key_commit_n = 1'b0;
        key_clear_n  = 1'b0;

        // Full write of ABCD to r5, overflow past four digits, ignored keys in
        // IDLE, ack held high, and an all-zero value written to r15.
        vecs.push_back('{OP_DIGIT,  4'hA, 4'h0, 0, 16'h000A, 3'd1});
        vecs.push_back('{OP_DIGIT,  4'hB, 4'h0, 0, 16'h00AB, 3'd2});
        vecs.push_back('{OP_DIGIT,  4'hC, 4'h0, 0, 16'h0ABC, 3'd3});
        vecs.push_back('{OP_DIGIT,  4'hD, 4'h0, 0, 16'hABCD, 3'd4});
        vecs.push_back('{OP_COMMIT, 4'h0, 4'h5, 3, 16'h0000, 3'd0});
        vecs.push_back('{OP_DIGIT,  4'h1, 4'h0, 0, 16'h0001, 3'd1});
        vecs.push_back('{OP_DIGIT,  4'h2, 4'h0, 0, 16'h0012, 3'd2});
        vecs.push_back('{OP_DIGIT,  4'h3, 4'h0, 0, 16'h0123, 3'd3});
        vecs.push_back('{OP_DIGIT,  4'h4, 4'h0, 0, 16'h1234, 3'd4});
        vecs.push_back('{OP_DIGIT,  4'h5, 4'h0, 0, 16'h1234, 3'd4});
        vecs.push_back('{OP_CLEAR,  4'h0, 4'h0, 0, 16'h0000, 3'd0});
        vecs.push_back('{OP_CLEAR,  4'h0, 4'h0, 0, 16'h0000, 3'd0});
        vecs.push_back('{OP_COMMIT, 4'h0, 4'h2, 1, 16'h0000, 3'd0});
        vecs.push_back('{OP_DIGIT,  4'hF, 4'h0, 0, 16'h000F, 3'd1});
        vecs.push_back('{OP_COMMIT, 4'h0, 4'h9, 0, 16'h0000, 3'd0});
        vecs.push_back('{OP_DIGIT,  4'h0, 4'h0, 0, 16'h0000, 3'd1});
        vecs.push_back('{OP_COMMIT, 4'h0, 4'hF, 2, 16'h0000, 3'd0});

        // Reset held with every key pressed.
        repeat (3) @(negedge clk);
        checkOutput("rst_wr_req", 32'(wr_req), 32'd0);
        checkOutput("rst_wr_addr", 32'(wr_addr), 32'd0);
        checkOutput("rst_wr_data", 32'(wr_data), 32'd0);
        checkOutput("rst_entry_val", 32'(entry_val), 32'd0);
        checkOutput("rst_digit_cnt", 32'(digit_cnt), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        key_digit_n  = 1'b1;
        key_commit_n = 1'b1;
        key_clear_n  = 1'b1;
        @(negedge clk);
        resetn  = 1'b1;
        saw_req = 1'b0;
        tick(20);
        checkOutput("post_rst_entry", 32'(entry_val), 32'd0);
        checkOutput("post_rst_cnt", 32'(digit_cnt), 32'd0);
        checkOutput("post_rst_no_req", 32'(saw_req), 32'd0);

        for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

        // Bouncing digit key settles low: only one digit is taken.
        sw = 4'h3;
        for (int i = 0; i < 10; i++) begin
            key_digit_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            tick(2);
        end
        key_digit_n = 1'b0;
        tick(D + 6);
        key_digit_n = 1'b1;
        tick(D + 6);
        checkOutput("bounce_entry", 32'(entry_val), 32'h0003);
        checkOutput("bounce_cnt", 32'(digit_cnt), 32'd1);
        pressKeys(1'b0, 1'b0, 1'b1);
        checkOutput("bounce_cleared", 32'(entry_val), 32'd0);

        // Commit and clear in the same cycle: clear wins, no write.
        sw = 4'h7;
        pressKeys(1'b1, 1'b0, 1'b0);
        checkOutput("sim_entry_7", 32'(entry_val), 32'h0007);
        reg_sel = 4'h4;
        saw_req = 1'b0;
        pressKeys(1'b0, 1'b1, 1'b1);
        checkOutput("sim_entry", 32'(entry_val), 32'd0);
        checkOutput("sim_cnt", 32'(digit_cnt), 32'd0);
        checkOutput("sim_no_req", 32'(saw_req), 32'd0);
        sw = 4'h8;
        pressKeys(1'b1, 1'b0, 1'b0);
        checkOutput("sim_back_in_idle", 32'(entry_val), 32'h0008);

        // Clear pressed while the write is outstanding is ignored.
        reg_sel = 4'h3;
        key_commit_n = 1'b0;
        tick(D + 6);
        key_commit_n = 1'b1;
        tick(D + 6);
        checkOutput("wclr_req_up", 32'(wr_req), 32'd1);
        pressKeys(1'b0, 1'b0, 1'b1);
        checkOutput("wclr_req_held", 32'(wr_req), 32'd1);
        checkOutput("wclr_busy", 32'(busy), 32'd1);
        checkOutput("wclr_addr", 32'(wr_addr), 32'h3);
        checkOutput("wclr_data", 32'(wr_data), 32'h0008);
        checkOutput("wclr_entry", 32'(entry_val), 32'h0008);
        wr_ack = 1'b1;
        @(negedge clk);
        wr_ack = 1'b0;
        checkOutput("wclr_req_done", 32'(wr_req), 32'd0);
        checkOutput("wclr_entry_done", 32'(entry_val), 32'd0);
        checkOutput("wclr_cnt_done", 32'(digit_cnt), 32'd0);

        // Reset in the middle of a write drops it immediately and for good.
        sw = 4'h9;
        pressKeys(1'b1, 1'b0, 1'b0);
        reg_sel = 4'h6;
        key_commit_n = 1'b0;
        tick(D + 6);
        checkOutput("mrst_req_up", 32'(wr_req), 32'd1);
        #3 resetn = 1'b0;
        #1;
        checkOutput("mrst_req_async", 32'(wr_req), 32'd0);
        checkOutput("mrst_busy_async", 32'(busy), 32'd0);
        checkOutput("mrst_data_async", 32'(wr_data), 32'd0);
        checkOutput("mrst_entry_async", 32'(entry_val), 32'd0);
        key_commit_n = 1'b1;
        @(negedge clk);
        resetn  = 1'b1;
        saw_req = 1'b0;
        tick(20);
        checkOutput("mrst_no_retry", 32'(saw_req), 32'd0);
        checkOutput("mrst_cnt", 32'(digit_cnt), 32'd0);
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hex_entry_controller.md
# hex_entry_controller

Front-panel input block for the 16-bit CPU board. The operator builds a 16-bit hex value one nibble at a time from SW[3:0] and push buttons, then commits it to a selected register. Commits go out as a held write request with acknowledge to the register-file write port. `entry_val` is the in-progress value and feeds the seven-segment display path so the operator sees digits as they are entered.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable cycles required before a debounced key level changes (1 ms at 50 MHz). The counter width is derived from this value.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `sw`  in  4  nibble value to shift in.
- `reg_sel`  in  4  destination register index, sampled at commit.
- `key_digit_n`  in  1  raw active-low button: enter nibble.
- `key_commit_n`  in  1  raw active-low button: commit value.
- `key_clear_n`  in  1  raw active-low button: discard entry.
- `wr_ack`  in  1  register file has accepted the write.
- `wr_req`  out  1  write request, held until acknowledged.
- `wr_addr`  out  4  destination register; stable while `wr_req`=1.
- `wr_data`  out  16  write value; stable while `wr_req`=1.
- `entry_val`  out  16  value under construction, for display.
- `digit_cnt`  out  3  digits entered so far, range 0..4.
- `busy`  out  1  high while in WRITE.

## Operation

Key conditioning is identical for each of the three keys:
- 2-flop synchronizer feeds a debouncer.
- The debounced level changes only after the synchronized input has differed from it for `DEBOUNCE_CYCLES` consecutive cycles. Any return to the current level resets the count to 0.
- Press event: a one-cycle pulse on a debounced 1->0 transition. Releases produce no event.
- Reset values: debounced level 1 (released), count 0, no events.

State machine. States are IDLE, ENTRY, WRITE. Reset state is IDLE.

- **IDLE** (`entry_val`=0, `digit_cnt`=0)
  - digit event: `entry_val` <= {12'h000, `sw`}, `digit_cnt` <= 1, go to ENTRY.
  - commit and clear events are ignored.
- **ENTRY**
  - digit event with `digit_cnt`<4: `entry_val` <= {`entry_val`[11:0], `sw`}, `digit_cnt` increments.
  - digit event with `digit_cnt`=4: ignored, no change.
  - commit event: `wr_addr` <= `reg_sel`, `wr_data` <= `entry_val`, `wr_req` <= 1, go to WRITE.
  - clear event: `entry_val` <= 0, `digit_cnt` <= 0, go to IDLE.
  - Events in the same cycle resolve by priority: clear > commit > digit. Lower-priority events that cycle are dropped.
- **WRITE**
  - `busy`=1. `wr_req`, `wr_addr` and `wr_data` are held unchanged.
  - All key events are dropped, including clear.
  - On `wr_ack`=1 sampled: `wr_req` <= 0, `entry_val` <= 0, `digit_cnt` <= 0, go to IDLE.

Other rules:
- `wr_ack` is ignored outside WRITE.
- Exactly one write is issued per commit.
- Reset values of all outputs: `wr_req`=0, `wr_addr`=0, `wr_data`=0, `entry_val`=0, `digit_cnt`=0, `busy`=0.
- Reset asserted at any time, including mid-WRITE, clears every output immediately (asynchronously). The pending write is abandoned, not retried.

## Timing

- Raw press to event pulse: 2 synchronizer cycles + `DEBOUNCE_CYCLES` + 1 cycles, for a clean press.
- `entry_val` and `digit_cnt` update on the edge after the event pulse.
- `wr_req` rises on the edge after the commit event.
- `wr_req` is high for at least 1 cycle. With `wr_ack` sampled high in cycle N, `wr_req` is 0 from cycle N+1.
- `wr_ack` may be held high continuously. Each commit still completes after exactly 1 `wr_req` cycle, and only one write results per commit.
- `busy` equals (state==WRITE) and is registered together with `wr_req`.
- In the IDLE cycle following a write, new key events are accepted normally.

## Test plan

All scenarios use `DEBOUNCE_CYCLES`=4.

1. Reset: hold `resetn`=0 with all keys pressed -> all outputs 0. After release with keys released, no events for 20 cycles.
2. Full write: clean digit presses with `sw`=A,B,C,D, then commit with `reg_sel`=5; `wr_ack` asserted 3 cycles after `wr_req` rises -> `wr_addr`=5 and `wr_data`=16'hABCD held stable, `wr_req` high exactly 3 cycles, then `entry_val`=0, `digit_cnt`=0, `busy`=0.
3. Bounce: `key_digit_n` toggles every 2 cycles for 20 cycles then stays low, `sw`=3 -> exactly one digit entered: `entry_val`=16'h0003, `digit_cnt`=1.
4. Overflow: digits 1,2,3,4,5 entered -> `entry_val`=16'h1234, `digit_cnt`=4.
5. Simultaneous events: after entering 7, commit and clear events land in the same cycle -> `entry_val`=0, IDLE, no `wr_req`. Separately, a clear press while in WRITE -> ignored, `wr_data` unchanged.
6. Reset mid-write: `resetn` driven low while `wr_req`=1 and `wr_ack`=0 -> `wr_req`=0 the same cycle, IDLE after release, no write issued afterwards.
